gb_lcd_capture: RTL

//  Receiving end of the PPU pixel stream (PX_OUT/PX_valid/PPU_MODE). Tracks screen x/y, packs four
//  2-bit pixels per byte and writes them into a 160x144 frame buffer (40 bytes/line) through a
//  2-entry write FIFO with a valid/ready handshake. Feeds the video-out side that scans the buffer.

---
 rtl/gb_lcd_capture_if.sv | 13 +
 rtl/gb_lcd_capture.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/gb_lcd_capture_if.sv
// Frame-buffer write port of gb_lcd_capture: a valid/ready byte-write bus.
// The capture block drives it as master and the frame buffer answers as slave.
interface gb_lcd_capture_if #(
  parameter int FB_ADDR_W = 13
) ();
  logic                 FB_WR;
  logic                 FB_READY;
  logic [FB_ADDR_W-1:0] FB_ADDR;
  logic [7:0]           FB_DATA;

  modport master (output FB_WR, FB_ADDR, FB_DATA, input FB_READY);
  modport slave  (input FB_WR, FB_ADDR, FB_DATA, output FB_READY);
endinterface

// File: rtl/gb_lcd_capture.sv
// PPU pixel stream -> 2bpp packed frame-buffer writes through a 2-entry write FIFO.
// Define GB_LCD_PALETTE_EN to map each pixel through BGP before packing.
module gb_lcd_capture #(
  parameter int H_PIXELS  = 160,
  parameter int V_LINES   = 144,
  parameter int FB_ADDR_W = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] PX_OUT,
  input  logic       PX_valid,
  input  logic [1:0] PPU_MODE,
  input  logic       LCD_EN,
  input  logic       ERR_CLR,
`ifdef GB_LCD_PALETTE_EN
  input  logic [7:0] BGP,
`endif
  gb_lcd_capture_if.master fb,
  output logic       FRAME_DONE,
  output logic [7:0] CUR_LY,
  output logic       OVF,
  output logic       LINE_ERR
);
  typedef enum logic [1:0] {DISABLED, CAPTURE, LINE_WAIT, FRAME_WAIT} state_t;
  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [7:0]           data;
  } fb_ent_t;

  state_t     state, state_n;
  logic [7:0] x, x_n, y, y_n, y_inc, pk, pk_n, byte_v, push_data;
  logic [5:0] push_g;
  logic [1:0] prev_mode, px_c, cnt;
  logic       hb_edge, vb_edge, push, pop, lerr, pend, pend_set, fire, ovf_set;
  fb_ent_t    head, tail, ent;

`ifdef GB_LCD_PALETTE_EN
  assign px_c = BGP[{PX_OUT, 1'b0} +: 2];
`else
  assign px_c = PX_OUT;
`endif

  assign hb_edge = (prev_mode == 2'd3) && (PPU_MODE == 2'd0);
  assign vb_edge = (prev_mode != 2'd1) && (PPU_MODE == 2'd1);
  assign y_inc   = (y == 8'hFF) ? y : y + 8'd1;
  assign byte_v  = pk | (8'(px_c) << {x[1:0], 1'b0});

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= DISABLED;
    else     state <= state_n;

  // Pixel is applied first; a mode edge in the same cycle then sees the updated x/packer.
  always_comb begin
    state_n   = state;
    x_n       = x;
    y_n       = y;
    pk_n      = pk;
    push      = 1'b0;
    push_g    = x[7:2];
    push_data = byte_v;
    lerr      = 1'b0;
    pend_set  = 1'b0;
    case (state)
      DISABLED: begin
        x_n  = '0;
        y_n  = '0;
        pk_n = '0;
        if (LCD_EN) state_n = CAPTURE;
      end
      CAPTURE: begin
        if (PX_valid) begin
          if (y >= 8'(V_LINES)) lerr = 1'b1;
          else begin
            x_n = x + 8'd1;
            if (x[1:0] == 2'd3) begin
              push = 1'b1;
              pk_n = '0;
            end else pk_n = byte_v;
            if (x_n == 8'(H_PIXELS)) state_n = LINE_WAIT;
          end
        end
        if (hb_edge) begin
          if (x_n < 8'(H_PIXELS)) begin
            lerr = 1'b1;
            if (x_n[1:0] != 2'd0) begin
              push      = 1'b1;
              push_g    = x_n[7:2];
              push_data = pk_n;
            end
          end
          x_n     = '0;
          y_n     = y_inc;
          pk_n    = '0;
          state_n = CAPTURE;
        end else if (vb_edge) begin
          x_n      = '0;
          y_n      = '0;
          pk_n     = '0;
          pend_set = 1'b1;
          state_n  = FRAME_WAIT;
        end
      end
      LINE_WAIT: begin
        if (PX_valid) lerr = 1'b1;
        if (hb_edge) begin
          x_n     = '0;
          y_n     = y_inc;
          state_n = CAPTURE;
        end else if (vb_edge) begin
          x_n      = '0;
          y_n      = '0;
          pk_n     = '0;
          pend_set = 1'b1;
          state_n  = FRAME_WAIT;
        end
      end
      default: begin
        x_n  = '0;
        y_n  = '0;
        pk_n = '0;
        if (PPU_MODE == 2'd2) state_n = CAPTURE;
      end
    endcase
    if (!LCD_EN) begin
      state_n = DISABLED;
      x_n     = '0;
      y_n     = '0;
      pk_n    = '0;
      push    = 1'b0;
      lerr    = 1'b0;
    end
  end

  assign ent.addr = FB_ADDR_W'(y) * FB_ADDR_W'(H_PIXELS / 4) + FB_ADDR_W'(push_g);
  assign ent.data = push_data;

  assign pop        = (cnt != 2'd0) && fb.FB_READY;
  assign ovf_set    = push && (cnt == 2'd2) && !pop;
  assign fire       = pend && (cnt == 2'd0) && (x[1:0] == 2'd0) && !push;
  assign fb.FB_WR   = (cnt != 2'd0);
  assign fb.FB_ADDR = head.addr;
  assign fb.FB_DATA = head.data;
  assign CUR_LY     = y;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      x          <= '0;
      y          <= '0;
      pk         <= '0;
      prev_mode  <= '0;
      pend       <= 1'b0;
      FRAME_DONE <= 1'b0;
      OVF        <= 1'b0;
      LINE_ERR   <= 1'b0;
    end else begin
      x          <= x_n;
      y          <= y_n;
      pk         <= pk_n;
      prev_mode  <= PPU_MODE;
      pend       <= pend_set | (pend & ~fire);
      FRAME_DONE <= fire;
      OVF        <= ovf_set | (OVF & ~ERR_CLR);
      LINE_ERR   <= lerr | (LINE_ERR & ~ERR_CLR);
    end

  // Head is the presented entry; a push into a full FIFO only lands when the head pops.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt  <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      case (cnt)
        2'd0: if (push) begin
          head <= ent;
          cnt  <= 2'd1;
        end
        2'd1: begin
          if (push && pop) head <= ent;
          else if (push) begin
            tail <= ent;
            cnt  <= 2'd2;
          end else if (pop) cnt <= 2'd0;
        end
        default: if (pop) begin
          head <= tail;
          if (push) tail <= ent;
          else      cnt  <= 2'd1;
        end
      endcase
    end
endmodule
